// File: rtl/buffer_rec_spi_data.sv
// Collects the SPI header and the read-back byte into a {id, select, reg, data} word held under a valid/ack handshake.
// Define SPI_RX_TIMEOUT_EN to close a stalled transaction with data 8'hFF and timeout_err after TIMEOUT_CYCLES.
module buffer_rec_spi_data #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  spi_id_in,
    input  logic [7:0]  spi_select_in,
    input  logic [7:0]  spi_reg_in,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    input  logic        data_rec_ack,
    output logic [31:0] data_rec_out,
    output logic        data_rec_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, WAIT_BYTE, HOLD} state_t;

    state_t state;

    // A counter narrower than the timeout threshold could never reach it.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 ||
        (64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_check
        $error("buffer_rec_spi_data: TIMEOUT_CYCLES/CNT_W out of range");
    end

`ifdef SPI_RX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            data_rec_out   <= 32'h0;
            data_rec_valid <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
            timeout_err    <= 1'b0;
            cnt            <= '0;
`endif
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        data_rec_out <= {spi_id_in, spi_select_in, spi_reg_in, 8'h00};
                        state        <= WAIT_BYTE;
                        busy         <= 1'b1;
                        overrun      <= rx_byte_valid;
`ifdef SPI_RX_TIMEOUT_EN
                        cnt          <= '0;
`endif
                    end else if (rx_byte_valid) begin
                        overrun <= 1'b1;
                    end
                end

                // A byte on the final counted cycle still wins over the timeout.
                WAIT_BYTE: begin
                    if (rx_byte_valid) begin
                        data_rec_out[7:0] <= rx_byte;
                        data_rec_valid    <= 1'b1;
                        state             <= HOLD;
                        overrun           <= start;
                    end else begin
                        overrun <= start;
`ifdef SPI_RX_TIMEOUT_EN
                        if (cnt == TIMEOUT_LAST) begin
                            data_rec_out[7:0] <= 8'hFF;
                            data_rec_valid    <= 1'b1;
                            timeout_err       <= 1'b1;
                            state             <= HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                end

                HOLD: begin
                    if (data_rec_ack) begin
                        data_rec_valid <= 1'b0;
                        overrun        <= rx_byte_valid;
`ifdef SPI_RX_TIMEOUT_EN
                        timeout_err    <= 1'b0;
`endif
                        if (start) begin
                            data_rec_out <= {spi_id_in, spi_select_in, spi_reg_in, 8'h00};
                            state        <= WAIT_BYTE;
`ifdef SPI_RX_TIMEOUT_EN
                            cnt          <= '0;
`endif
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        overrun <= start | rx_byte_valid;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_rec_spi_data.sv
// Scoreboard bench for buffer_rec_spi_data; the timeout scenarios follow SPI_RX_TIMEOUT_EN.
module tb_buffer_rec_spi_data;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  spi_id_in;
    logic [7:0]  spi_select_in;
    logic [7:0]  spi_reg_in;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic        data_rec_ack;
    logic [31:0] data_rec_out;
    logic        data_rec_valid;
    logic        busy;
    logic        timeout_err;
    logic        overrun;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [23:0] hdr;

    always #5 clk = ~clk;

    buffer_rec_spi_data #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .spi_id_in(spi_id_in), .spi_select_in(spi_select_in), .spi_reg_in(spi_reg_in),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .data_rec_ack(data_rec_ack),
        .data_rec_out(data_rec_out), .data_rec_valid(data_rec_valid), .busy(busy),
        .timeout_err(timeout_err), .overrun(overrun)
    );

    task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepted start: the bench model takes the new header.
    task automatic apply_start(input logic [7:0] id, input logic [7:0] sel, input logic [7:0] rg);
        start = 1'b1; spi_id_in = id; spi_select_in = sel; spi_reg_in = rg;
        hdr = {id, sel, rg};
        step();
        start = 1'b0;
    endtask

    task automatic drop_start(input logic [7:0] id, input logic [7:0] sel, input logic [7:0] rg);
        start = 1'b1; spi_id_in = id; spi_select_in = sel; spi_reg_in = rg;
        step();
        start = 1'b0;
    endtask

    task automatic apply_byte(input logic [7:0] b);
        rx_byte = b; rx_byte_valid = 1'b1;
        exp_q.push_back({1'b0, hdr, b});
        step();
        rx_byte_valid = 1'b0;
    endtask

    task automatic wait_word(input string tag, input int budget);
        int          n = 0;
        logic [32:0] e;
        while (!data_rec_valid && n < budget) begin
            step();
            n++;
        end
        check_output({tag, " valid"}, {31'h0, data_rec_valid}, 32'h1);
        if (data_rec_valid) begin
            if (exp_q.size() == 0) begin
                check_output({tag, " unexpected word"}, {31'h0, data_rec_valid}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check_output({tag, " word"}, data_rec_out, e[31:0]);
                check_output({tag, " timeout_err"}, {31'h0, timeout_err}, {31'h0, e[32]});
            end
        end
    endtask

    task automatic ack_word();
        data_rec_ack = 1'b1;
        step();
        data_rec_ack = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; rx_byte_valid = 1'b0; data_rec_ack = 1'b0;
        spi_id_in = 8'h0; spi_select_in = 8'h0; spi_reg_in = 8'h0; rx_byte = 8'h0;
        hdr = 24'h0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        step();

        check_output("reset out", data_rec_out, 32'h0);
        check_output("reset valid", {31'h0, data_rec_valid}, 32'h0);
        check_output("reset busy", {31'h0, busy}, 32'h0);
        check_output("reset timeout", {31'h0, timeout_err}, 32'h0);
        check_output("reset overrun", {31'h0, overrun}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            data_rec_ack = i[0]; spi_id_in = 8'(i * 17); rx_byte = 8'(i * 3);
            step();
            check_output("idle out", data_rec_out, 32'h0);
            check_output("idle busy", {31'h0, busy}, 32'h0);
            check_output("idle overrun", {31'h0, overrun}, 32'h0);
        end
        data_rec_ack = 1'b0;

        apply_start(8'h12, 8'h34, 8'h56);
        check_output("basic header", data_rec_out, 32'h12345600);
        check_output("basic busy wait", {31'h0, busy}, 32'h1);
        check_output("basic no valid", {31'h0, data_rec_valid}, 32'h0);
        repeat (4) step();
        apply_byte(8'hA7);
        wait_word("basic", 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check_output("basic hold word", data_rec_out, 32'h123456A7);
            check_output("basic hold valid", {31'h0, data_rec_valid}, 32'h1);
            check_output("basic hold busy", {31'h0, busy}, 32'h1);
        end
        ack_word();
        check_output("basic ack valid", {31'h0, data_rec_valid}, 32'h0);
        check_output("basic ack busy", {31'h0, busy}, 32'h0);

        apply_start(8'hAA, 8'hBB, 8'hCC);
        apply_byte(8'h11);
        wait_word("b2b first", 0);
        data_rec_ack = 1'b1;
        apply_start(8'h01, 8'h02, 8'h03);
        data_rec_ack = 1'b0;
        check_output("b2b valid", {31'h0, data_rec_valid}, 32'h0);
        check_output("b2b busy", {31'h0, busy}, 32'h1);
        check_output("b2b header", data_rec_out, 32'h01020300);
        apply_byte(8'h44);
        wait_word("b2b second", 0);
        ack_word();

        rx_byte = 8'h55; rx_byte_valid = 1'b1;
        step();
        rx_byte_valid = 1'b0;
        check_output("ovr idle pulse", {31'h0, overrun}, 32'h1);
        check_output("ovr idle valid", {31'h0, data_rec_valid}, 32'h0);
        check_output("ovr idle busy", {31'h0, busy}, 32'h0);
        step();
        check_output("ovr idle clear", {31'h0, overrun}, 32'h0);

        rx_byte = 8'h66; rx_byte_valid = 1'b1;
        apply_start(8'h21, 8'h22, 8'h23);
        rx_byte_valid = 1'b0;
        check_output("ovr start+byte pulse", {31'h0, overrun}, 32'h1);
        check_output("ovr start+byte header", data_rec_out, 32'h21222300);
        drop_start(8'h77, 8'h88, 8'h99);
        check_output("ovr wait pulse", {31'h0, overrun}, 32'h1);
        check_output("ovr wait header", data_rec_out, 32'h21222300);
        step();
        check_output("ovr wait clear", {31'h0, overrun}, 32'h0);
        apply_byte(8'h5A);
        wait_word("ovr wait", 0);
        rx_byte = 8'hEE; rx_byte_valid = 1'b1;
        step();
        rx_byte_valid = 1'b0;
        check_output("ovr hold pulse", {31'h0, overrun}, 32'h1);
        check_output("ovr hold word", data_rec_out, 32'h2122235A);
        drop_start(8'h31, 8'h32, 8'h33);
        check_output("ovr hold start pulse", {31'h0, overrun}, 32'h1);
        check_output("ovr hold start word", data_rec_out, 32'h2122235A);
        ack_word();
        check_output("ovr ack clear", {31'h0, overrun}, 32'h0);

`ifdef SPI_RX_TIMEOUT_EN
        apply_start(8'h12, 8'h34, 8'h56);
        exp_q.push_back({1'b1, hdr, 8'hFF});
        n = 0;
        while (!data_rec_valid && n < 20) begin
            step();
            n++;
        end
        check_output("timeout latency", 32'(n), 32'(TO));
        wait_word("timeout", 0);
        ack_word();
        check_output("timeout cleared", {31'h0, timeout_err}, 32'h0);

        apply_start(8'h12, 8'h34, 8'h56);
        repeat (TO - 1) step();
        check_output("late byte still waiting", {31'h0, data_rec_valid}, 32'h0);
        apply_byte(8'hB3);
        wait_word("late byte", 0);
        ack_word();
`else
        apply_start(8'h12, 8'h34, 8'h56);
        repeat (2000) step();
        check_output("no timeout busy", {31'h0, busy}, 32'h1);
        check_output("no timeout valid", {31'h0, data_rec_valid}, 32'h0);
        check_output("no timeout err", {31'h0, timeout_err}, 32'h0);
        apply_byte(8'hB3);
        wait_word("slow byte", 0);
        ack_word();
`endif

        apply_start(8'h41, 8'h42, 8'h43);
        apply_byte(8'h44);
        wait_word("pre reset", 0);
        #2 rst = 1'b0;
        #1;
        check_output("async rst out", data_rec_out, 32'h0);
        check_output("async rst valid", {31'h0, data_rec_valid}, 32'h0);
        check_output("async rst busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_output("post rst busy", {31'h0, busy}, 32'h0);
        check_output("post rst valid", {31'h0, data_rec_valid}, 32'h0);
        apply_start(8'h0A, 8'h0B, 8'h0C);
        apply_byte(8'h0D);
        wait_word("post rst", 0);
        ack_word();
        check_output("post rst done", {31'h0, busy}, 32'h0);
        check_output("queue drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_rec_spi_data.md
Name: buffer_rec_spi_data

Overview:
Receive-side counterpart of the SPI transmit buffer. It latches the SPI transaction header (id, select, register) when a transaction starts and waits for the read-back byte from the SPI shifter. It then assembles a 32-bit word {id, select, reg, data} for the Object Dictionary / CAN transmit side. The word is held with a valid/ack handshake; the block also provides overrun detection and an optional timeout.

Parameters:
TIMEOUT_CYCLES, 1024, number of consecutive WAIT_BYTE cycles without rx_byte_valid before a timeout (used only with SPI_RX_TIMEOUT_EN; legal range 2..65535)
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; an SPI transaction has been launched, header inputs valid this cycle
spi_id_in  input  8  SPI device id of the launched transaction
spi_select_in  input  8  chip-select code of the launched transaction
spi_reg_in  input  8  register address of the launched transaction
rx_byte  input  8  byte received from the SPI shifter
rx_byte_valid  input  1  single-cycle pulse, rx_byte valid
data_rec_ack  input  1  consumer accepts data_rec_out
data_rec_out  output  32  {id[31:24], select[23:16], reg[15:8], data[7:0]}
data_rec_valid  output  1  data_rec_out holds a complete word
busy  output  1  high in WAIT_BYTE and HOLD
timeout_err  output  1  word was closed by timeout; held with data_rec_valid
overrun  output  1  single-cycle pulse on a dropped start or dropped rx_byte_valid

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, data_rec_out=32'h0, data_rec_valid=0, busy=0, timeout_err=0, overrun=0, counter=0. Reset during WAIT_BYTE or HOLD aborts the transaction immediately; no word is produced.
- All outputs are registered.
- IDLE:
  - start=1: latch the header into [31:8], clear [7:0], go to WAIT_BYTE.
  - rx_byte_valid=1 without start: ignored, overrun=1 for one cycle.
  - start and rx_byte_valid in the same cycle: start is accepted, the byte is dropped, overrun=1.
- WAIT_BYTE:
  - rx_byte_valid=1: latch rx_byte into [7:0], go to HOLD. data_rec_valid is high from the next cycle (1-cycle latency).
  - start=1 with no rx_byte_valid: dropped, header unchanged, overrun=1.
  - start and rx_byte_valid together: the byte is taken, the start is dropped, overrun=1.
  - Counter increments every WAIT_BYTE cycle and is cleared on entry.
- HOLD:
  - data_rec_valid=1 and data_rec_out stable until data_rec_ack=1.
  - On ack: data_rec_valid=0 and timeout_err=0 on the next edge; go to IDLE.
  - Ack and start in the same cycle: go directly to WAIT_BYTE with the new header latched (back-to-back, no IDLE cycle); data_rec_valid drops.
  - start without ack: dropped, overrun=1.
  - rx_byte_valid: dropped, overrun=1.
- busy = (state != IDLE), registered with the state.
- data_rec_ack outside HOLD: ignored.
- overrun is never sticky; multiple drop conditions in one cycle produce a single pulse.

Optional Feature:
SPI_RX_TIMEOUT_EN
- Defined:
  - If the counter reaches TIMEOUT_CYCLES-1 in WAIT_BYTE with no rx_byte_valid, the next edge sets data[7:0]=8'hFF, timeout_err=1, state HOLD, data_rec_valid=1.
  - A byte arriving on that same final cycle wins: normal completion, timeout_err=0.
  - The counter and timeout_err logic exist only under this macro.
- Undefined:
  - No counter; WAIT_BYTE waits indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- Reset then idle: all outputs 0, busy=0 for 10 cycles with inputs toggling except start and rx_byte_valid.
- Basic: start with id=8'h12, select=8'h34, reg=8'h56; 5 cycles later rx_byte=8'hA7 valid. Next cycle data_rec_out=32'h123456A7, data_rec_valid=1, busy=1; hold ack low 8 cycles (word stable), then ack. Next cycle valid=0, busy=0.
- Back-to-back: in HOLD, ack plus start with header 8'h01/8'h02/8'h03. Next cycle state WAIT_BYTE, valid=0, busy=1; byte 8'h44 then gives 32'h01020344.
- Overrun:
  - rx_byte_valid in IDLE: 1-cycle overrun pulse, no valid.
  - Second start in WAIT_BYTE: overrun pulse, the original header is retained in the output.
  - rx_byte_valid in HOLD: overrun pulse, word unchanged.
- Timeout (macro defined, TIMEOUT_CYCLES=8):
  - start, no byte: after 8 WAIT_BYTE cycles data_rec_out=32'h123456FF, timeout_err=1, valid=1.
  - Repeat with the byte on the 8th cycle: normal word, timeout_err=0.
  - Macro undefined: no completion after 2000 cycles, busy=1.
- Reset mid-transaction: assert rst low asynchronously (between clock edges) while in HOLD. Outputs go to 0 immediately, state IDLE after release; the next transaction completes normally.
